// File: rtl/wb_regfile_pkg.sv
// Shared register-file constants and the scoreboard counter width helper.
// Also imported by decode and the forwarding unit.
package wb_regfile_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;

  // Bits needed to hold an in-flight writer count of 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Bus between decode/writeback (master) and the register file (slave).
//
// Handshake: an instruction is accepted on a rising edge where
// issue_valid & issue_we & issue_ready are all high; its destination counter
// then counts one more pending writer. issue_ready is combinational and only
// depends on issue_rd and the same-cycle writeback. Presenting an issue while
// issue_ready is low is an error: the increment is dropped and sb_overflow
// latches. Writeback (WE_WB/RD_WB/Final_Result) has no back-pressure.
interface wb_regfile_if
  import wb_regfile_pkg::*;
#(
  parameter int size = 32
);

  logic [REG_ADDR_W-1:0] RD_WB;
  logic                  WE_WB;
  logic [size-1:0]       Final_Result;
  logic                  issue_valid;
  logic                  issue_we;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic [REG_ADDR_W-1:0] rs1_addr;
  logic [REG_ADDR_W-1:0] rs2_addr;
  logic [size-1:0]       rs1_data;
  logic [size-1:0]       rs2_data;
  logic                  rs1_pending;
  logic                  rs2_pending;
  logic                  issue_ready;
  logic                  sb_overflow;

  modport master (
    output RD_WB, WE_WB, Final_Result,
    output issue_valid, issue_we, issue_rd,
    output rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, rs1_pending, rs2_pending,
    input  issue_ready, sb_overflow
  );

  modport slave (
    input  RD_WB, WE_WB, Final_Result,
    input  issue_valid, issue_we, issue_rd,
    input  rs1_addr, rs2_addr,
    output rs1_data, rs2_data, rs1_pending, rs2_pending,
    output issue_ready, sb_overflow
  );

endinterface

// File: rtl/wb_regfile_sb_counter.sv
// In-flight writer counter for one architectural register. Counts 0..depth,
// never wraps. `dec` is the raw writeback hit; a hit on an empty counter is
// reported as underflow and leaves the count at 0.
module sb_counter
  import wb_regfile_pkg::*;
#(
  parameter int depth = 3,
  parameter int width = cnt_width(depth)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [width-1:0] cnt,
  output logic             at_max,
  output logic             underflow
);

  logic dec_eff;

  // Only a writeback against a non-zero count actually retires a writer.
  always_comb begin
    dec_eff   = dec && (cnt != '0);
    underflow = dec && (cnt == '0);
    at_max    = (cnt == width'(depth));
  end

  // Simultaneous inc and dec cancel; otherwise step by one, clamped at both ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && !dec_eff && !at_max) begin
      cnt <= cnt + width'(1);
    end else if (dec_eff && !inc) begin
      cnt <= cnt - width'(1);
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// RV32I architectural register file x0..x31: two combinational read ports
// with writeback bypass, plus a per-register in-flight writer scoreboard.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int size  = 32,
  parameter int depth = 3
) (
  input  logic        clk,
  input  logic        reset,
  wb_regfile_if.slave bus
);

  localparam int CW = cnt_width(depth);

  logic [size-1:0]      regs [REG_COUNT];
  logic [CW-1:0]        cnt  [REG_COUNT];
  logic [REG_COUNT-1:0] at_max;
  logic [REG_COUNT-1:0] underflow;
  logic                 wr_en;
  logic                 issue_req;
  logic                 issue_fire;

  // Decode the writeback and issue qualifiers shared by all registers.
  always_comb begin
    wr_en       = bus.WE_WB && (bus.RD_WB != '0);
    issue_req   = bus.issue_valid && bus.issue_we && (bus.issue_rd != '0);
    // A full counter still accepts a new writer if one retires this cycle.
    // at_max[0] is tied low, so x0 is always ready.
    bus.issue_ready = !(at_max[bus.issue_rd] &&
                        !(bus.WE_WB && (bus.RD_WB == bus.issue_rd)));
    issue_fire  = issue_req && bus.issue_ready;
  end

  // x0 has no counter: constant zero, never full, never underflows.
  assign cnt[0]       = '0;
  assign at_max[0]    = 1'b0;
  assign underflow[0] = 1'b0;

  for (genvar r = 1; r < REG_COUNT; r++) begin : g_sb
    logic inc_r;
    logic dec_r;

    // Per-register issue and writeback hits.
    always_comb begin
      inc_r = issue_fire && (bus.issue_rd == REG_ADDR_W'(r));
      dec_r = bus.WE_WB && (bus.RD_WB == REG_ADDR_W'(r));
    end

    sb_counter #(
      .depth (depth),
      .width (CW)
    ) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc_r),
      .dec       (dec_r),
      .cnt       (cnt[r]),
      .at_max    (at_max[r]),
      .underflow (underflow[r])
    );
  end

  // Register storage; x0 is held at zero and never written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[bus.RD_WB] <= bus.Final_Result;
    end
  end

  // Read port 1: x0 reads zero, a same-cycle writeback wins over storage.
  always_comb begin
    bus.rs1_data = regs[bus.rs1_addr];
    if (bus.rs1_addr == '0) begin
      bus.rs1_data = '0;
    end else if (bus.WE_WB && (bus.RD_WB == bus.rs1_addr)) begin
      bus.rs1_data = bus.Final_Result;
    end
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    bus.rs2_data = regs[bus.rs2_addr];
    if (bus.rs2_addr == '0) begin
      bus.rs2_data = '0;
    end else if (bus.WE_WB && (bus.RD_WB == bus.rs2_addr)) begin
      bus.rs2_data = bus.Final_Result;
    end
  end

  // A source is pending unless its count is zero, or its last writer
  // retires in this very cycle.
  always_comb begin
    bus.rs1_pending = (cnt[bus.rs1_addr] != '0) &&
                      !((cnt[bus.rs1_addr] == CW'(1)) && bus.WE_WB &&
                        (bus.RD_WB == bus.rs1_addr));
    bus.rs2_pending = (cnt[bus.rs2_addr] != '0) &&
                      !((cnt[bus.rs2_addr] == CW'(1)) && bus.WE_WB &&
                        (bus.RD_WB == bus.rs2_addr));
  end

  // Sticky error: issue into a full counter, or writeback with no writer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.sb_overflow <= 1'b0;
    end else if ((issue_req && !bus.issue_ready) ||
                 (wr_en && underflow[bus.RD_WB])) begin
      bus.sb_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus random traffic,
// checked against a behavioural model through an expected-value queue.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  localparam int SIZE  = 32;
  localparam int DEPTH = 3;

  logic clk;
  logic reset;

  wb_regfile_if #(.size(SIZE)) bus ();

  wb_regfile #(
    .size  (SIZE),
    .depth (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  logic [SIZE-1:0] exp_q[$];
  int              n_checks = 0;
  int              n_fail   = 0;

  logic [SIZE-1:0] m_reg [REG_COUNT];
  int              m_cnt [REG_COUNT];
  logic            m_ovf;

  task automatic check(input string tag, input logic [SIZE-1:0] obs,
                       input logic [SIZE-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < REG_COUNT; i++) begin
      m_reg[i] = '0;
      m_cnt[i] = 0;
    end
    m_ovf = 1'b0;
  endtask

  // ---------------- behavioural model of the outputs ----------------
  function automatic logic [SIZE-1:0] m_data(input logic [4:0] a);
    if (a == 0) return '0;
    if (bus.WE_WB && bus.RD_WB == a) return bus.Final_Result;
    return m_reg[a];
  endfunction

  function automatic logic [SIZE-1:0] m_pend(input logic [4:0] a);
    int left;
    left = m_cnt[a];
    if (bus.WE_WB && bus.RD_WB == a && m_cnt[a] != 0) left = left - 1;
    return (left != 0) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic m_ready();
    if (bus.issue_rd == 0) return 1'b1;
    if (m_cnt[bus.issue_rd] != DEPTH) return 1'b1;
    return bus.WE_WB && bus.RD_WB == bus.issue_rd;
  endfunction

  // ---------------- driver tasks ----------------
  // Apply one cycle of inputs, queue the model's expectations, compare.
  task automatic drive(input logic we, input logic [4:0] rd, input logic [SIZE-1:0] fr,
                       input logic iv, input logic iwe, input logic [4:0] ird,
                       input logic [4:0] a1, input logic [4:0] a2);
    bus.WE_WB        = we;
    bus.RD_WB        = rd;
    bus.Final_Result = fr;
    bus.issue_valid  = iv;
    bus.issue_we     = iwe;
    bus.issue_rd     = ird;
    bus.rs1_addr     = a1;
    bus.rs2_addr     = a2;
    exp_q.push_back(m_data(a1));
    exp_q.push_back(m_data(a2));
    exp_q.push_back(m_pend(a1));
    exp_q.push_back(m_pend(a2));
    exp_q.push_back({31'd0, m_ready()});
    exp_q.push_back({31'd0, m_ovf});
    #1;
    check("rs1_data",    bus.rs1_data,              exp_q.pop_front());
    check("rs2_data",    bus.rs2_data,              exp_q.pop_front());
    check("rs1_pending", {31'd0, bus.rs1_pending},  exp_q.pop_front());
    check("rs2_pending", {31'd0, bus.rs2_pending},  exp_q.pop_front());
    check("issue_ready", {31'd0, bus.issue_ready},  exp_q.pop_front());
    check("sb_overflow", {31'd0, bus.sb_overflow},  exp_q.pop_front());
  endtask

  // Advance the model over the coming edge, then step to the next negedge.
  task automatic tick();
    logic rdy, hit_i, hit_w, inc, dec;
    if (reset) begin
      model_clear();
    end else begin
      rdy   = m_ready();
      hit_i = bus.issue_valid && bus.issue_we && bus.issue_rd != 0;
      hit_w = bus.WE_WB && bus.RD_WB != 0;
      if (hit_i && !rdy) m_ovf = 1'b1;
      if (hit_w && m_cnt[bus.RD_WB] == 0) m_ovf = 1'b1;
      inc = hit_i && rdy;
      dec = hit_w && m_cnt[bus.RD_WB] != 0;
      if (!(inc && dec && bus.issue_rd == bus.RD_WB)) begin
        if (inc) m_cnt[bus.issue_rd] = m_cnt[bus.issue_rd] + 1;
        if (dec) m_cnt[bus.RD_WB] = m_cnt[bus.RD_WB] - 1;
      end
      if (hit_w) m_reg[bus.RD_WB] = bus.Final_Result;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert reset between edges and check the outputs clear with no clock.
  task automatic async_reset();
    bus.WE_WB       = 1'b0;
    bus.issue_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("rst_rs1_data",    bus.rs1_data,             '0);
    check("rst_rs1_pending", {31'd0, bus.rs1_pending}, '0);
    check("rst_issue_ready", {31'd0, bus.issue_ready}, 32'd1);
    check("rst_sb_overflow", {31'd0, bus.sb_overflow}, '0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0]      r_rd, r_ird, r_a1, r_a2;
    logic [SIZE-1:0] r_fr;
    model_clear();
    reset = 1'b1;
    drive(1'b0, 5'd0, '0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);

    // Reset: write during reset is ignored, then a real write, then async clear.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    reset = 1'b0;
    drive(1'b0, 5'd0, '0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0);
    check("t1_write_in_reset_dropped", bus.rs1_data, '0);
    tick();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0);
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0);
    check("t1_stored", bus.rs1_data, 32'hDEADBEEF);
    async_reset();

    // x0: writes discarded, issue to x0 is always ready and harmless.
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    check("t2_x0_bypass", bus.rs1_data, '0);
    tick();
    drive(1'b0, 5'd0, '0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    check("t2_x0_ready", {31'd0, bus.issue_ready}, 32'd1);
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    check("t2_x0_no_ovf", {31'd0, bus.sb_overflow}, '0);
    tick();

    // Bypass on x7.
    drive(1'b1, 5'd7, 32'h11, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7);
    tick();
    drive(1'b1, 5'd7, 32'h22, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7);
    check("t3_bypass", bus.rs2_data, 32'h22);
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7);
    check("t3_storage", bus.rs2_data, 32'h22);
    tick();

    // Scoreboard fill / overflow / drain on x3 (x7 writes above were unissued).
    async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd0, '0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0);
      tick();
    end
    drive(1'b0, 5'd0, '0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0);
    check("t4_full_pending", {31'd0, bus.rs1_pending}, 32'd1);
    check("t4_full_not_ready", {31'd0, bus.issue_ready}, '0);
    tick();
    drive(1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0);
    check("t4_overflow_set", {31'd0, bus.sb_overflow}, 32'd1);
    tick();
    drive(1'b1, 5'd3, 32'h34, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0);
    tick();
    drive(1'b1, 5'd3, 32'h35, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0);
    check("t4_last_wb_not_pending", {31'd0, bus.rs1_pending}, '0);
    tick();

    // Simultaneous issue and writeback on x9 with one writer in flight.
    drive(1'b0, 5'd0, '0, 1'b1, 1'b1, 5'd9, 5'd9, 5'd0);
    tick();
    drive(1'b1, 5'd9, 32'h99, 1'b1, 1'b1, 5'd9, 5'd9, 5'd0);
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 1'b0, 5'd0, 5'd9, 5'd0);
    check("t5_still_pending", {31'd0, bus.rs1_pending}, 32'd1);
    tick();

    // Underflow on x12: data still written, flag set, counter stays 0.
    async_reset();
    drive(1'b1, 5'd12, 32'h1234, 1'b0, 1'b0, 5'd0, 5'd12, 5'd0);
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 1'b0, 5'd0, 5'd12, 5'd12);
    check("t6_data", bus.rs1_data, 32'h1234);
    check("t6_overflow", {31'd0, bus.sb_overflow}, 32'd1);
    check("t6_cnt_zero", {31'd0, bus.rs2_pending}, '0);
    tick();

    // Random traffic concentrated on a few registers to exercise the counters.
    async_reset();
    for (int n = 0; n < 400; n++) begin
      r_rd  = 5'($urandom_range(0, 4));
      r_ird = 5'($urandom_range(0, 4));
      r_a1  = 5'($urandom_range(0, 5));
      r_a2  = 5'($urandom_range(0, 5));
      r_fr  = $urandom;
      drive(1'($urandom_range(0, 1)), r_rd, r_fr,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r_ird, r_a1, r_a2);
      tick();
      if (n == 200) async_reset();
    end

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL exp_q_drain: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
